// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the instruction-fetch front end.
//    DEFAULT_RESET_PC : boot vector fetched first after reset
//    INST_W           : instruction width in bits
//    PC_STEP          : byte distance between sequential fetches
//    fetch_entry_t    : one queued fetch {pc, inst, adel}
//    isMisaligned()   : true when a PC is not word aligned
// -----------------------------------------------------------------------------
package cpu_defs;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
   localparam int          INST_W           = 32;
   localparam logic [31:0] PC_STEP          = 32'd4;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
      logic              adel;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // The low PC bits are kept so the address-error exception can report the
   // exact faulting PC further down the pipe.
   function automatic logic isMisaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with flush, used to buffer fetched instructions.
// Ports:
//    clk, reset   : clock and synchronous active-high reset
//    push_i       : write push_data_i at the tail
//    push_data_i  : entry to write
//    pop_i        : remove the head entry (ignored when empty)
//    flush_i      : drop every entry; has priority over push/pop
//    count_o      : number of entries held
//    valid_o      : head entry is valid
//    head_o       : head entry; holds the last shown head while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         valid_o,
   output logic [WIDTH-1:0]             head_o
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] lastHead_q, lastHead_d;
   logic             doPush;
   logic             doPop;
   logic             notEmpty;

   assign notEmpty = (count_q != '0);
   assign doPop    = pop_i & notEmpty;
   assign doPush   = push_i & (count_q != CW'(DEPTH));

   // Next-state for pointers and occupancy. Pointers wrap naturally because
   // DEPTH is a power of two. lastHead tracks whatever is on the head output
   // so the outputs freeze rather than show a stale slot once the FIFO drains.
   always_comb begin
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      lastHead_d = lastHead_q;
      if (notEmpty) begin
         lastHead_d = mem_q[rdPtr_q];
      end
      if (flush_i) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
         end
         if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         lastHead_q <= '0;
      end else begin
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         lastHead_q <= lastHead_d;
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (!reset && !flush_i && doPush) begin
         mem_q[wrPtr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign valid_o = notEmpty;
   assign head_o  = notEmpty ? mem_q[rdPtr_q] : lastHead_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
// Fetch front end between the synchronous inst_sram and the ID stage. Issues
// one sequential fetch per cycle and buffers {pc, inst, adel} entries.
// Ports:
//    clk, reset        : clock and synchronous active-high reset
//    redirect_valid    : flush everything and restart fetch at redirect_pc
//    redirect_pc       : new fetch PC (may be misaligned)
//    inst_sram_en      : fetch request this cycle
//    inst_sram_addr    : word-aligned fetch address
//    inst_sram_rdata   : read data, valid the cycle after inst_sram_en
//    out_valid/ready   : handshake to ID (ready = ID_allow_in)
//    out_pc/inst/adel  : head entry
//    count             : entries held
// -----------------------------------------------------------------------------
module inst_prefetch_queue
   import cpu_defs::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        redirect_valid,
   input  logic [31:0]                 redirect_pc,
   output logic                        inst_sram_en,
   output logic [31:0]                 inst_sram_addr,
   input  logic [31:0]                 inst_sram_rdata,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [31:0]                 out_pc,
   output logic [INST_W-1:0]           out_inst,
   output logic                        out_adel,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]  fetchPc_q, fetchPc_d;
   logic [31:0]  issuedPc_q, issuedPc_d;
   logic         inflight_q, inflight_d;
   logic         discard_q, discard_d;
   logic [CW:0]  credit;
   logic         issue;
   logic         push;
   logic         pop;
   fetch_entry_t pushEntry;
   fetch_entry_t headEntry;
   logic [CW-1:0] fifoCount;
   logic         fifoValid;

   // Credits count both held entries and the outstanding request, so the
   // FIFO can never overflow. A pop in the same cycle does not free a credit.
   assign credit = {1'b0, fifoCount} + {{CW{1'b0}}, inflight_q};
   assign issue  = ~reset & ~redirect_valid & (credit < (CW+1)'(DEPTH));

   assign push = inflight_q & ~discard_q & ~redirect_valid;
   assign pop  = fifoValid & out_ready & ~redirect_valid;

   assign pushEntry = '{pc: issuedPc_q, inst: inst_sram_rdata,
                        adel: isMisaligned(issuedPc_q)};

   // Fetch sequencing. The SRAM always answers on the following cycle, so
   // the request in flight at a redirect is answered in that same cycle and
   // dropped there; no request is left outstanding and discard stays clear.
   always_comb begin
      fetchPc_d  = fetchPc_q;
      issuedPc_d = issuedPc_q;
      inflight_d = issue;
      discard_d  = discard_q & ~inflight_q;
      if (redirect_valid) begin
         fetchPc_d = redirect_pc;
         discard_d = 1'b0;
      end else if (issue) begin
         fetchPc_d  = fetchPc_q + PC_STEP;
         issuedPc_d = fetchPc_q;
      end
   end

   // Fetch state registers; reset overrides redirect and all traffic.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetchPc_q  <= RESET_PC;
         issuedPc_q <= '0;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         fetchPc_q  <= fetchPc_d;
         issuedPc_q <= issuedPc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (pushEntry),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .count_o     (fifoCount),
      .valid_o     (fifoValid),
      .head_o      (headEntry)
   );

   assign inst_sram_en   = issue;
   assign inst_sram_addr = {fetchPc_q[31:2], 2'b00};
   assign out_valid      = fifoValid;
   assign out_pc         = headEntry.pc;
   assign out_inst       = headEntry.inst;
   assign out_adel       = headEntry.adel;
   assign count          = fifoCount;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch_queue
// Directed bench for inst_prefetch_queue with a one-cycle-latency SRAM model
// whose data is the fetch address XOR a fixed key.
// -----------------------------------------------------------------------------
module tb_inst_prefetch_queue;

   localparam logic [31:0] KEY = 32'h5a5aa5a5;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_adel;
   logic [2:0]  count;

   int testsRun;
   int testsFailed;

   inst_prefetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'hbfc00000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .out_adel        (out_adel),
      .count           (count)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous SRAM model: data appears the cycle after the request.
   initial inst_sram_rdata = '0;
   always @(posedge clk) begin
      if (inst_sram_en) begin
         inst_sram_rdata <= inst_sram_addr ^ KEY;
      end
   end

   function automatic logic [31:0] expInst(input logic [31:0] pc);
      return {pc[31:2], 2'b00} ^ KEY;
   endfunction

   task automatic applyStimulus(input logic r, input logic rv,
                                input logic [31:0] rpc, input logic rdy);
      reset          = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;

      // Reset state, then steady sequential fetch from the boot vector.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick(); #1;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_en", 32'(inst_sram_en), 32'd0);
      checkOutput("rst_pc", out_pc, 32'h0);
      checkOutput("rst_inst", out_inst, 32'h0);
      checkOutput("rst_adel", 32'(out_adel), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t1_en_c1", 32'(inst_sram_en), 32'd1);
      checkOutput("t1_addr_c1", inst_sram_addr, 32'hbfc00000);
      tick(); #1;
      checkOutput("t1_addr_c2", inst_sram_addr, 32'hbfc00004);
      checkOutput("t1_valid_c2", 32'(out_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick(); #1;
         checkOutput("t1_valid", 32'(out_valid), 32'd1);
         checkOutput("t1_pc", out_pc, 32'hbfc00000 + 32'(4 * k));
         checkOutput("t1_inst", out_inst, expInst(32'hbfc00000 + 32'(4 * k)));
         checkOutput("t1_count", 32'(count), 32'd1);
      end

      // Back-pressure: queue fills to 4, then drains in order.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (9) tick();
      #1;
      checkOutput("t2_full_count", 32'(count), 32'd4);
      checkOutput("t2_full_en", 32'(inst_sram_en), 32'd0);
      checkOutput("t2_full_pc", out_pc, 32'hbfc00000);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t2_popfull_en", 32'(inst_sram_en), 32'd0);
      tick(); #1;
      checkOutput("t2_pc1", out_pc, 32'hbfc00004);
      checkOutput("t2_count1", 32'(count), 32'd3);
      checkOutput("t2_refetch_en", 32'(inst_sram_en), 32'd1);
      checkOutput("t2_refetch_addr", inst_sram_addr, 32'hbfc00010);
      tick(); #1;
      checkOutput("t2_pc2", out_pc, 32'hbfc00008);
      checkOutput("t2_count2", 32'(count), 32'd2);
      tick(); #1;
      checkOutput("t2_pc3", out_pc, 32'hbfc0000c);
      tick(); #1;
      checkOutput("t2_pc4", out_pc, 32'hbfc00010);
      checkOutput("t2_inst4", out_inst, expInst(32'hbfc00010));

      // Redirect with count=3 and a response arriving.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      #1;
      checkOutput("t3_pre_count", 32'(count), 32'd3);
      applyStimulus(1'b0, 1'b1, 32'h80001000, 1'b0); #1;
      checkOutput("t3_redir_en", 32'(inst_sram_en), 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0); #1;
      checkOutput("t3_flush_count", 32'(count), 32'd0);
      checkOutput("t3_flush_valid", 32'(out_valid), 32'd0);
      checkOutput("t3_hold_pc", out_pc, 32'hbfc00000);
      checkOutput("t3_en", 32'(inst_sram_en), 32'd1);
      checkOutput("t3_addr", inst_sram_addr, 32'h80001000);
      tick(); #1;
      checkOutput("t3_valid_c2", 32'(out_valid), 32'd0);
      checkOutput("t3_addr_c2", inst_sram_addr, 32'h80001004);
      tick(); #1;
      checkOutput("t3_valid_c3", 32'(out_valid), 32'd1);
      checkOutput("t3_pc_c3", out_pc, 32'h80001000);
      checkOutput("t3_inst_c3", out_inst, expInst(32'h80001000));
      checkOutput("t3_count_c3", 32'(count), 32'd1);

      // Misaligned redirect target.
      tick();
      applyStimulus(1'b0, 1'b1, 32'h80000002, 1'b1); #1;
      checkOutput("t4_redir_en", 32'(inst_sram_en), 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t4_count", 32'(count), 32'd0);
      checkOutput("t4_addr", inst_sram_addr, 32'h80000000);
      tick(); #1;
      checkOutput("t4_addr2", inst_sram_addr, 32'h80000004);
      tick(); #1;
      checkOutput("t4_pc", out_pc, 32'h80000002);
      checkOutput("t4_adel", 32'(out_adel), 32'd1);
      checkOutput("t4_inst", out_inst, expInst(32'h80000000));
      tick(); #1;
      checkOutput("t4_pc2", out_pc, 32'h80000006);
      checkOutput("t4_adel2", 32'(out_adel), 32'd1);

      // Address wrap and simultaneous push/pop at count=2.
      tick();
      applyStimulus(1'b0, 1'b1, 32'hfffffff8, 1'b1); #1;
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t5_addr_f8", inst_sram_addr, 32'hfffffff8);
      tick(); #1;
      checkOutput("t5_addr_fc", inst_sram_addr, 32'hfffffffc);
      tick(); #1;
      checkOutput("t5_addr_wrap", inst_sram_addr, 32'h00000000);
      checkOutput("t5_pc_f8", out_pc, 32'hfffffff8);
      tick(); #1;
      checkOutput("t5_pc_fc", out_pc, 32'hfffffffc);
      checkOutput("t5_adel_fc", 32'(out_adel), 32'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0); #1;
      checkOutput("t5_pc_0", out_pc, 32'h00000000);
      checkOutput("t5_inst_0", out_inst, expInst(32'h00000000));
      checkOutput("t5_count1", 32'(count), 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t5_count2", 32'(count), 32'd2);
      checkOutput("t5_pc_hold", out_pc, 32'h00000000);
      tick(); #1;
      checkOutput("t5_pushpop_count", 32'(count), 32'd2);
      checkOutput("t5_pc_4", out_pc, 32'h00000004);

      // Reset mid-stream overrides a concurrent redirect.
      applyStimulus(1'b1, 1'b1, 32'h80000000, 1'b1); #1;
      checkOutput("t6_en_rst", 32'(inst_sram_en), 32'd0);
      tick(); #1;
      checkOutput("t6_count", 32'(count), 32'd0);
      checkOutput("t6_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_pc", out_pc, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1); #1;
      checkOutput("t6_en", 32'(inst_sram_en), 32'd1);
      checkOutput("t6_addr", inst_sram_addr, 32'hbfc00000);
      tick(); #1;
      checkOutput("t6_addr2", inst_sram_addr, 32'hbfc00004);
      tick(); #1;
      checkOutput("t6_first_pc", out_pc, 32'hbfc00000);
      checkOutput("t6_first_valid", 32'(out_valid), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
